// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and the
// round-robin search used to pick the next requester.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

  // Search is sized for the largest supported requester count; callers pad.
  localparam int RR_MAX = 8;

  typedef struct packed {
    logic       any;
    logic [2:0] idx;
  } rr_result_t;

  // First set bit of req[0..n-1], scanning from (last+1) mod n.
  function automatic rr_result_t rr_search(input logic [RR_MAX-1:0] req,
                                           input logic [2:0]        last,
                                           input int                n);
    rr_result_t res;
    int         p;
    logic [2:0] pos;
    res.any = 1'b0;
    res.idx = 3'd0;
    for (int k = 1; k <= RR_MAX; k++) begin
      if (!res.any && (k <= n)) begin
        p   = (int'(last) + k) % n;
        pos = p[2:0];
        if (req[pos]) begin
          res.any = 1'b1;
          res.idx = pos;
        end else begin
          res.any = 1'b0;
        end
      end else begin
        res.any = res.any;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: combinational wrapper around the shared search.
import uart_pkg::*;

module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     any
);

  localparam int ID_W = $clog2(N_REQ);

  logic [RR_MAX-1:0] req_pad_s;
  logic [2:0]        last_pad_s;
  rr_result_t        res_s;

  // Pad to the package search width and pick the next requester.
  always_comb begin
    req_pad_s              = {RR_MAX{1'b0}};
    req_pad_s[N_REQ-1:0]   = req;
    last_pad_s             = 3'd0;
    last_pad_s[ID_W-1:0]   = last_grant;
    res_s                  = rr_search(req_pad_s, last_pad_s, N_REQ);
    winner                 = res_s.idx[ID_W-1:0];
    any                    = res_s.any;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources,
// with a launch handshake and a sticky timeout if the transmitter never goes busy.
import uart_pkg::*;

module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      grant_valid,
  output logic                      err_timeout
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_FULL = CNT_W'(BUSY_TIMEOUT);

  tx_state_e          state_r,       state_s;
  logic [ID_W-1:0]    grant_id_r,    grant_id_s;
  logic [ID_W-1:0]    last_grant_r,  last_grant_s;
  logic [DATA_W-1:0]  tx_data_r,     tx_data_s;
  logic               grant_valid_r, grant_valid_s;
  logic               err_timeout_r, err_timeout_s;
  logic [CNT_W-1:0]   cnt_r,         cnt_s;
  logic [ID_W-1:0]    pick_id_s;
  logic               pick_any_s;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req        (req),
    .last_grant (last_grant_r),
    .winner     (pick_id_s),
    .any        (pick_any_s)
  );

  // State and datapath registers; reset leaves requester 0 first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      grant_id_r    <= {ID_W{1'b0}};
      last_grant_r  <= ID_W'(N_REQ - 1);
      tx_data_r     <= {DATA_W{1'b0}};
      grant_valid_r <= 1'b0;
      err_timeout_r <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
    end else begin
      state_r       <= state_s;
      grant_id_r    <= grant_id_s;
      last_grant_r  <= last_grant_s;
      tx_data_r     <= tx_data_s;
      grant_valid_r <= grant_valid_s;
      err_timeout_r <= err_timeout_s;
      cnt_r         <= cnt_s;
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_s       = state_r;
    grant_id_s    = grant_id_r;
    last_grant_s  = last_grant_r;
    tx_data_s     = tx_data_r;
    grant_valid_s = grant_valid_r;
    err_timeout_s = err_timeout_r;
    cnt_s         = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s && !tx_busy) begin
          state_s       = ST_LAUNCH;
          grant_id_s    = pick_id_s;
          last_grant_s  = pick_id_s;
          tx_data_s     = req_data[pick_id_s*DATA_W +: DATA_W];
          grant_valid_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_s = ST_WAIT_BUSY;
        cnt_s   = {CNT_W{1'b0}};
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_s = ST_WAIT_DONE;
        end else if (cnt_r >= TO_LAST) begin
          // Transmitter never acknowledged the launch: give up on this grant.
          state_s       = ST_IDLE;
          cnt_s         = TO_FULL;
          err_timeout_s = 1'b1;
          grant_valid_s = 1'b0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_s       = ST_IDLE;
          grant_valid_s = 1'b0;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_s       = ST_IDLE;
        grant_valid_s = 1'b0;
      end
    endcase
  end

  // Launch strobes are decoded straight from the LAUNCH state.
  always_comb begin
    ack      = {N_REQ{1'b0}};
    tx_start = 1'b0;
    if (state_r == ST_LAUNCH) begin
      tx_start            = 1'b1;
      ack[grant_id_r]     = 1'b1;
    end else begin
      tx_start = 1'b0;
    end
  end

  assign tx_data     = tx_data_r;
  assign grant_id    = grant_id_r;
  assign grant_valid = grant_valid_r;
  assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, DATA_W=8, BUSY_TIMEOUT=15).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        grant_valid;
  logic        err_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int ack_cnt   = 0;
  int viol_cnt  = 0;
  int bad_ack   = 0;

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .BUSY_TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Pulse and protocol monitor, sampled mid-cycle after inputs settle.
  always @(negedge clk) begin
    #1;
    if (tx_start) start_cnt = start_cnt + 1;
    if (ack != 4'b0000) ack_cnt = ack_cnt + 1;
    if (tx_start && tx_busy) viol_cnt = viol_cnt + 1;
    if (ack != (tx_start ? (4'b0001 << grant_id) : 4'b0000)) bad_ack = bad_ack + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for tx_start; returns cycles from call to the launch cycle.
  task automatic wait_start(input string tag, output int lat);
    bit ok;
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_start) begin
        ok  = 1'b1;
        lat = i + 1;
        break;
      end
    end
    chk({tag, "_start_seen"}, {31'd0, ok}, 32'd1);
  endtask

  // Transmitter model: busy rises dly cycles after the launch cycle, lasts len.
  task automatic busy_pulse(input int dly, input int len);
    repeat (dly) @(negedge clk);
    tx_busy = 1'b1;
    repeat (len) @(negedge clk);
    tx_busy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int lat;
  int k;
  int s0;
  int a0;

  initial begin
    clk = 1'b0; rst = 1'b1; req = 4'b0000; req_data = 32'h0; tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_grant_valid", {31'd0, grant_valid}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single request from requester 2
    s0 = start_cnt; a0 = ack_cnt;
    req_data = {8'h5A, 8'hA5, 8'h3C, 8'hC3};
    req = 4'b0100;
    wait_start("single", lat);
    chk("single_latency", lat, 32'd1);
    chk("single_ack", {28'd0, ack}, 32'h4);
    chk("single_tx_data", {24'd0, tx_data}, 32'hA5);
    chk("single_grant_id", {30'd0, grant_id}, 32'd2);
    chk("single_grant_valid", {31'd0, grant_valid}, 32'd1);
    req = 4'b0000;
    busy_pulse(2, 11);
    repeat (3) @(negedge clk);
    chk("single_gv_drop", {31'd0, grant_valid}, 32'd0);
    chk("single_data_hold", {24'd0, tx_data}, 32'hA5);
    chk("single_id_hold", {30'd0, grant_id}, 32'd2);
    chk("single_starts", start_cnt - s0, 32'd1);
    chk("single_acks", ack_cnt - a0, 32'd1);

    // Round robin with all requesters pending
    do_reset();
    s0 = start_cnt; a0 = ack_cnt;
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    req = 4'b1111;
    for (int f = 0; f < 4; f++) begin
      wait_start("rr", lat);
      chk("rr_grant_id", {30'd0, grant_id}, f);
      chk("rr_ack", {28'd0, ack}, 32'd1 << f);
      chk("rr_tx_data", {24'd0, tx_data}, 32'h10 + 32'h11 * f);
      busy_pulse(2, 3);
    end
    req = 4'b0000;
    repeat (4) @(negedge clk);
    chk("rr_starts", start_cnt - s0, 32'd4);
    chk("rr_acks", ack_cnt - a0, 32'd4);

    // Busy timeout: transmitter never responds
    req = 4'b0001;
    wait_start("to", lat);
    chk("to_grant_id", {30'd0, grant_id}, 32'd0);
    req = 4'b0000;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      k++;
      if (err_timeout) break;
    end
    chk("to_err_delay", k, 32'd16);
    chk("to_err_set", {31'd0, err_timeout}, 32'd1);
    chk("to_gv_drop", {31'd0, grant_valid}, 32'd0);
    repeat (5) @(negedge clk);
    chk("to_err_sticky", {31'd0, err_timeout}, 32'd1);
    req = 4'b0100;
    wait_start("to_next", lat);
    chk("to_back_idle_lat", lat, 32'd1);
    chk("to_next_id", {30'd0, grant_id}, 32'd2);
    req = 4'b0000;
    busy_pulse(2, 3);
    repeat (2) @(negedge clk);
    chk("to_err_still", {31'd0, err_timeout}, 32'd1);

    // Reset in the middle of a frame
    do_reset();
    chk("mr_err_cleared", {31'd0, err_timeout}, 32'd0);
    a0 = ack_cnt;
    req_data = {8'h44, 8'h33, 8'h77, 8'h11};
    req = 4'b0010;
    wait_start("mr", lat);
    chk("mr_grant_id", {30'd0, grant_id}, 32'd1);
    repeat (2) @(negedge clk);
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_tx_start", {31'd0, tx_start}, 32'd0);
    chk("mr_ack", {28'd0, ack}, 32'd0);
    chk("mr_gv", {31'd0, grant_valid}, 32'd0);
    chk("mr_tx_data", {24'd0, tx_data}, 32'd0);
    chk("mr_grant_id_rst", {30'd0, grant_id}, 32'd0);
    @(negedge clk);
    tx_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_start("mr_after", lat);
    chk("mr_after_lat", lat, 32'd1);
    chk("mr_after_id", {30'd0, grant_id}, 32'd1);
    chk("mr_after_ack", {28'd0, ack}, 32'h2);
    chk("mr_after_data", {24'd0, tx_data}, 32'h77);
    req = 4'b0000;
    busy_pulse(2, 3);
    repeat (4) @(negedge clk);
    chk("mr_total_acks", ack_cnt - a0, 32'd2);

    // Transmitter busy while idle holds off the launch
    s0 = start_cnt;
    tx_busy = 1'b1;
    req = 4'b0001;
    repeat (5) @(negedge clk);
    chk("bi_no_start", start_cnt - s0, 32'd0);
    chk("bi_no_grant", {31'd0, grant_valid}, 32'd0);
    tx_busy = 1'b0;
    wait_start("bi", lat);
    chk("bi_latency", lat, 32'd1);
    chk("bi_grant_id", {30'd0, grant_id}, 32'd0);
    chk("bi_tx_data", {24'd0, tx_data}, 32'h11);
    req = 4'b0000;
    busy_pulse(2, 3);
    repeat (2) @(negedge clk);

    // Back-to-back from two requesters
    do_reset();
    s0 = start_cnt;
    req = 4'b0011;
    for (int f = 0; f < 4; f++) begin
      wait_start("b2b", lat);
      chk("b2b_grant_id", {30'd0, grant_id}, f % 2);
      busy_pulse(2, 4);
    end
    req = 4'b0000;
    repeat (4) @(negedge clk);
    chk("b2b_starts", start_cnt - s0, 32'd4);
    chk("start_while_busy", viol_cnt, 32'd0);
    chk("ack_decode", bad_ack, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, is the number of requesters sharing one UART transmitter (range 2..8).
REQ-002 Parameter DATA_W, default 8, is the payload width per byte.
REQ-003 Parameter BUSY_TIMEOUT, default 15, is the maximum number of cycles to wait for tx_busy to rise after a launch.
REQ-004 The clock is clk and the reset is rst, asynchronous, active-high.
REQ-005 clk  input  1  system clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req  input  N_REQ  per-requester byte-pending request, level.
REQ-008 req_data  input  N_REQ*DATA_W  per-requester byte; slice i is bits [i*DATA_W +: DATA_W].
REQ-009 ack  output  N_REQ  one-hot, one-cycle pulse when the granted requester's byte has been captured.
REQ-010 tx_start  output  1  one-cycle launch pulse to the transmitter.
REQ-011 tx_data  output  DATA_W  byte presented to the transmitter, held stable from launch until the transmitter is idle.
REQ-012 tx_busy  input  1  transmitter busy flag.
REQ-013 grant_id  output  clog2(N_REQ)  index of the current or last grantee.
REQ-014 grant_valid  output  1  high from capture until the frame completes or is aborted.
REQ-015 err_timeout  output  1  sticky error flag; cleared only by rst.

Function
REQ-016 The FSM SHALL have four states: IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-017 IDLE behaviour:
- IDLE with any req bit high and tx_busy low goes to LAUNCH on the next edge.
- On that edge, capture the winner index into grant_id and its slice into tx_data.
- IDLE with tx_busy high stays in IDLE.
REQ-018 Round-robin: the search starts at (last_grant+1) mod N_REQ and the first set req bit wins.
REQ-019 last_grant SHALL update on capture, with wrap from N_REQ-1 to 0.
REQ-020 LAUNCH lasts exactly one cycle:
- tx_start=1 and ack[grant_id]=1 in the same cycle.
- Next state is WAIT_BUSY.
REQ-021 WAIT_BUSY behaviour:
- tx_busy=1 moves to WAIT_DONE.
- Otherwise a timeout counter increments.
- When the counter reaches BUSY_TIMEOUT, set err_timeout, drop grant_valid and go to IDLE.
REQ-022 WAIT_DONE: tx_busy=0 moves to IDLE, and the next grant may be captured in that same IDLE cycle at the earliest.
REQ-023 Latency from req rising in IDLE (bus idle) to tx_start SHALL be exactly 1 cycle; no new tx_start occurs while tx_busy=1.
REQ-024 Requesters SHALL drop req or present a new byte in the cycle after ack; a req still high after ack is treated as a new byte.
REQ-025 Request changes outside IDLE are ignored, and a req deasserted before capture is never granted.
REQ-026 Simultaneous requests are resolved solely by REQ-018; with all req high, grants cycle 0,1,2,3,0,...
REQ-027 tx_data and grant_id SHALL hold their values between captures.
REQ-028 The timeout counter SHALL clear on entry to WAIT_BUSY and saturate at BUSY_TIMEOUT.

Reset
REQ-029 On rst, all state and outputs SHALL reset immediately, with no partial launch:
- state=IDLE
- tx_start=0, ack=0, grant_valid=0, err_timeout=0
- tx_data=0, grant_id=0
- last_grant=N_REQ-1, so requester 0 has first priority
- timeout counter=0
REQ-030 An rst asserted mid-frame SHALL abandon the grant with no ack replay; after release, arbitration resumes per REQ-018 from requester 0.

Structure
REQ-031 FSM state encodings and the round-robin search function SHALL live in shared package uart_pkg.
REQ-032 Round-robin winner selection SHALL be sub-module rr_pick (inputs: req, last_grant; outputs: winner index, any).
REQ-033 The design SHALL contain no latches; all outputs SHALL be registered except ack and tx_start, which decode from state.

Verification
REQ-034 Single request: req=4'b0100, data2=8'hA5, tx_busy rising 2 cycles after tx_start for 11 cycles -> one tx_start, ack=4'b0100, tx_data=8'hA5, grant_id=2.
REQ-035 Round-robin: req=4'b1111 held for 4 frames -> grant_id sequence 0,1,2,3, with exactly four acks.
REQ-036 Timeout: tx_busy tied 0 -> err_timeout set 15 cycles after WAIT_BUSY entry, FSM returns to IDLE, err_timeout stays high.
REQ-037 Mid-frame reset: rst pulsed during WAIT_DONE with req=4'b0010 -> all outputs reset immediately; after release, requester 1 is granted with no duplicate ack.
REQ-038 Busy at idle: tx_busy=1 with req=4'b0001 -> no tx_start until tx_busy=0, then tx_start the next cycle.
REQ-039 Back-to-back: req=4'b0011 continuously -> tx_start never asserted while tx_busy=1, grants alternate 0,1.
